// File: rtl/lane_stripe_ctrl.sv
// Byte-striping controller: serial bytes onto 4 lanes, group handoff with pad/mask.
// Optional idle-flush counter enabled by defining FLUSH_TIMEOUT_EN.
module lane_stripe_ctrl #(
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned TIMEOUT  = 4
) (
    input  logic        clkf,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        flush,
    output logic [7:0]  out0,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic [3:0]  lane_mask,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] group_count
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic {FILL, HOLD} state_e;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("lane_stripe_ctrl: TIMEOUT must be in 1..255");
    end

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [LANES-1:0][BYTE_W-1:0]  lanes_q, lanes_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic                          valid_q, valid_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          accept;
    logic                          timeout_hit;
    logic                          flush_eff;
    logic                          close;

    assign ready_out = (state_q == FILL) | ((state_q == HOLD) & ready_in);
    assign accept    = valid_in & ready_out;
    assign flush_eff = flush | timeout_hit;

`ifdef FLUSH_TIMEOUT_EN
    // Idle counter: FILL cycles with a partial group and nothing accepted.
    logic [7:0] idle_q, idle_d;
    logic       idle_cycle;

    assign idle_cycle  = (state_q == FILL) & (idx_q != '0) & ~accept;
    assign timeout_hit = idle_cycle & (idle_q == 8'(TIMEOUT - 1));

    always_comb begin
        idle_d = '0;
        if (idle_cycle && !timeout_hit) begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_ff @(posedge clkf or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        count_d = count_q;
        close   = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    lanes_d[idx_q] = data_in;
                    mask_d[idx_q]  = 1'b1;
                    idx_d          = idx_q + IDX_W'(1);
                end
                if ((accept && idx_q == IDX_W'(LANES - 1)) ||
                    (flush_eff && (idx_q != '0 || accept))) begin
                    close = 1'b1;
                end
            end
            HOLD: begin
                if (ready_in) begin
                    count_d = count_q + CNT_W'(1);
                    lanes_d = {LANES{PAD_BYTE}};
                    mask_d  = '0;
                    idx_d   = '0;
                    state_d = FILL;
                    valid_d = 1'b0;
                    // New group's lane0 write overlaps the handoff cycle.
                    if (accept) begin
                        lanes_d[0] = data_in;
                        mask_d     = LANES'(1);
                        idx_d      = IDX_W'(1);
                        close      = flush_eff;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (close) begin
            state_d = HOLD;
            valid_d = 1'b1;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clkf or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            lanes_q <= {LANES{PAD_BYTE}};
            mask_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out0        = lanes_q[0];
    assign out1        = lanes_q[1];
    assign out2        = lanes_q[2];
    assign out3        = lanes_q[3];
    assign lane_mask   = mask_q;
    assign valid_out   = valid_q;
    assign group_count = count_q;

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Self-checking bench for lane_stripe_ctrl: queue-based group model plus directed literal checks.
module tb_lane_stripe_ctrl;

    localparam logic [7:0] PAD = 8'h00;
    localparam int         TO  = 4;

    logic        clkf = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        flush = 1'b0;
    logic [7:0]  out0, out1, out2, out3;
    logic [3:0]  lane_mask;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [15:0] group_count;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    lane_stripe_ctrl #(.PAD_BYTE(PAD), .TIMEOUT(TO)) dut (
        .clkf(clkf), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .flush(flush), .out0(out0), .out1(out1),
        .out2(out2), .out3(out3), .lane_mask(lane_mask), .valid_out(valid_out),
        .ready_in(ready_in), .group_count(group_count)
    );

    always #5 clkf = ~clkf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: bytes of the current (or presented) group, whether it is presented, handoff count.
    logic [7:0] m_q[$];
    bit         m_hold;
    int         m_count;
    int         m_idle;

    always @(posedge clkf or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_hold  = 1'b0;
            m_count = 0;
            m_idle  = 0;
        end else begin
            bit acc, fl;
            acc = valid_in && (!m_hold || ready_in);
            fl  = flush;
            if (!m_hold) begin
                if (acc) m_q.push_back(data_in);
`ifdef FLUSH_TIMEOUT_EN
                if (!acc && m_q.size() > 0) begin
                    m_idle++;
                    if (m_idle == TO) fl = 1'b1;
                end else begin
                    m_idle = 0;
                end
`endif
                if (m_q.size() == 4 || (fl && m_q.size() > 0)) begin
                    m_hold = 1'b1;
                    m_idle = 0;
                end
            end else if (ready_in) begin
                m_count = (m_count + 1) % 65536;
                m_q.delete();
                m_hold = 1'b0;
                if (acc) begin
                    m_q.push_back(data_in);
                    if (fl) m_hold = 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] m_lane(input int i);
        return (i < m_q.size()) ? m_q[i] : PAD;
    endfunction

    // Compare process: every cycle, after inputs have settled.
    always @(negedge clkf) begin
        #2;
        if (chk_en) begin
            chk("ready_out", 32'(ready_out), 32'(!m_hold || ready_in));
            chk("valid_out", 32'(valid_out), 32'(m_hold));
            chk("lane_mask", 32'(lane_mask), 32'((1 << m_q.size()) - 1));
            chk("out0", 32'(out0), 32'(m_lane(0)));
            chk("out1", 32'(out1), 32'(m_lane(1)));
            chk("out2", 32'(out2), 32'(m_lane(2)));
            chk("out3", 32'(out3), 32'(m_lane(3)));
            chk("group_count", 32'(group_count), 32'(m_count));
        end
    end

    // One clock cycle of stimulus; returns just after the following negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        valid_in = v; data_in = d; flush = f; ready_in = r;
        @(negedge clkf); #1;
    endtask

    task automatic do_reset();
        valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
        reset = 1'b0;
        @(negedge clkf); #1;
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clkf); #1;
        chk_en = 1'b1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_mask", 32'(lane_mask), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        reset = 1'b1;

        // Single full group and handoff.
        step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
        chk("t1_valid", 32'(valid_out), 32'd1);
        chk("t1_lanes", {out3, out2, out1, out0}, 32'h44332211);
        chk("t1_mask", 32'(lane_mask), 32'hF);
        step(0, 8'h00, 0, 1);
        chk("t1_valid_drop", 32'(valid_out), 32'd0);
        chk("t1_count", 32'(group_count), 32'd1);

        // 12 back-to-back bytes.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 8'(8'h30 + i), 0, 1);
            if (i == 11) chk("t2_last_lanes", {out3, out2, out1, out0}, 32'h3B3A3938);
        end
        step(0, 8'h00, 0, 1);
        chk("t2_count", 32'(group_count), 32'd3);

        // Downstream stall for 5 cycles with a byte waiting.
        do_reset();
        step(1, 8'hC1, 0, 0); step(1, 8'hC2, 0, 0); step(1, 8'hC3, 0, 0); step(1, 8'hC4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h99, 0, 0);
            chk("t3_ready_low", 32'(ready_out), 32'd0);
            chk("t3_held", {out3, out2, out1, out0}, 32'hC4C3C2C1);
        end
        step(1, 8'h99, 0, 1);
        chk("t3_new_lane0", 32'(out0), 32'h99);
        chk("t3_new_mask", 32'(lane_mask), 32'h1);
        chk("t3_count", 32'(group_count), 32'd1);

        // Partial group closed by flush, then flush with empty group ignored.
        do_reset();
        step(1, 8'hA1, 0, 1); step(1, 8'hA2, 0, 1); step(0, 8'h00, 1, 1);
        chk("t4_valid", 32'(valid_out), 32'd1);
        chk("t4_lanes", {out3, out2, out1, out0}, {PAD, PAD, 8'hA2, 8'hA1});
        chk("t4_mask", 32'(lane_mask), 32'h3);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("t4_empty_flush", 32'(valid_out), 32'd0);
        // Flush with a byte accepted during handoff: 1-byte group, stays presented.
        step(1, 8'hB1, 0, 1); step(1, 8'hB2, 1, 1);
        step(1, 8'hB3, 1, 1);
        chk("t4_hold_flush_valid", 32'(valid_out), 32'd1);
        chk("t4_hold_flush_mask", 32'(lane_mask), 32'h1);
        chk("t4_hold_flush_lane0", 32'(out0), 32'hB3);
        step(0, 8'h00, 0, 1);

        // Reset mid-group and in HOLD.
        step(1, 8'hD1, 0, 1); step(1, 8'hD2, 0, 1);
        reset = 1'b0; #1;
        chk("t5_mid_mask", 32'(lane_mask), 32'd0);
        chk("t5_mid_lanes", {out3, out2, out1, out0}, {4{PAD}});
        @(negedge clkf); #1; reset = 1'b1;
        step(1, 8'hE1, 0, 1); step(1, 8'hE2, 0, 1); step(1, 8'hE3, 0, 1); step(1, 8'hE4, 0, 0);
        chk("t5_clean_group", {out3, out2, out1, out0}, 32'hE4E3E2E1);
        step(0, 8'h00, 0, 0);
        reset = 1'b0; #1;
        chk("t5_hold_valid", 32'(valid_out), 32'd0);
        chk("t5_hold_count", 32'(group_count), 32'd0);
        @(negedge clkf); #1; reset = 1'b1;

        // Idle behaviour after a single byte.
        step(1, 8'h5A, 0, 1);
`ifdef FLUSH_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            step(0, 8'h00, 0, 0);
            chk("t6_timeout_valid", 32'(valid_out), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("t6_timeout_mask", 32'(lane_mask), 32'h1);
        step(0, 8'h00, 0, 1);
`else
        for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1);
        chk("t6_no_timeout", 32'(valid_out), 32'd0);
        step(0, 8'h00, 1, 1);
        chk("t6_flush_mask", 32'(lane_mask), 32'h1);
        step(0, 8'h00, 0, 1);
`endif
        step(0, 8'h00, 0, 1);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lane_stripe_ctrl.md
# lane_stripe_ctrl

Byte-striping controller for the 4-lane, 8-bit physical-layer datapath. Accepts a serial byte stream under a valid/ready handshake, distributes consecutive bytes onto lanes 0..3, and presents each completed lane group to the downstream 4-lane register stage with a group-valid/ready handshake. Partial groups are closed on request and padded, with a per-lane mask marking real data.

## Interface
- PAD_BYTE, 8'h00, value driven on lanes not carrying data in a closed group and on all lanes after reset
- TIMEOUT, 4, idle FILL cycles before an automatic flush (used only with FLUSH_TIMEOUT_EN); legal 1..255

- clkf  input  1  clock, all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- data_in  input  8  byte from upstream
- valid_in  input  1  data_in valid
- ready_out  output  1  controller accepts data_in this cycle (combinational)
- flush  input  1  close current partial group
- out0..out3  output  8 each  lane bytes, registered
- lane_mask  output  4  bit i = lane i carries real data, registered
- valid_out  output  1  lane group complete and presented, registered
- ready_in  input  1  downstream accepts group
- group_count  output  16  number of groups handed off, wraps 16'hFFFF -> 0

## Operation
- States: FILL (lane index idx 0..3), HOLD (group presented).
- ready_out = (state==FILL) | (state==HOLD & ready_in).
- Accept = valid_in & ready_out.
- FILL, accept: out[idx] <= data_in, lane_mask[idx] <= 1, idx++; if idx==3 -> HOLD, valid_out <= 1.
- FILL, flush=1 with idx>0 or accept: group closes after any same-cycle byte write; unwritten lanes stay PAD_BYTE; -> HOLD, valid_out <= 1, idx <= 0.
- FILL, flush=1, idx==0, no accept: ignored.
- HOLD, ready_in=0: all outputs held; ready_out=0; flush ignored.
- HOLD, ready_in=1: group_count++; lanes <= PAD_BYTE, mask <= 0, idx <= 0; if accept, byte written to lane0 of new group (mask 4'b0001, idx 1); -> FILL, valid_out <= 0. Flush on this cycle applies only if a byte is accepted (closes a 1-byte group, stays HOLD, valid_out stays 1).
- Lane outputs are updated during FILL; downstream samples only when valid_out=1.
- Reset (any time, incl. mid-group or in HOLD): out0..out3 = PAD_BYTE, lane_mask = 0, valid_out = 0, group_count = 0, idx = 0, state FILL; partial data discarded. ready_out = 1 while reset is deasserted in FILL.

## Timing
- Latency: lane-3 byte (or flush) accepted at edge k -> valid_out=1 after edge k.
- Handoff: valid_out & ready_in at edge m -> valid_out=0 after m unless a flush closes a new group at m.
- Sustained throughput: 4 bytes per 4 cycles with ready_in held high (HOLD->FILL overlaps with lane0 write).
- ready_out has a combinational path from ready_in; no other comb paths input->output.

## Configuration
- FLUSH_TIMEOUT_EN defined: 8-bit idle counter counts FILL cycles with idx>0 and no accept; reaching TIMEOUT acts as flush on that cycle; counter clears on accept, on group close and on reset.
- Undefined: no counter; partial groups close only via flush port. TIMEOUT unused.

## Test plan
- Reset then bytes 0x11,0x22,0x33,0x44 on consecutive cycles, ready_in=1 -> one cycle valid_out=1 with out0..3=11,22,33,44, lane_mask=4'hF; group_count=1 after handoff.
- 12 back-to-back bytes, ready_in=1 constant -> 3 groups, ready_out never low, group_count=3.
- Full group with ready_in=0 for 5 cycles -> ready_out=0, outputs stable 5 cycles, valid byte on data_in not consumed until ready_in=1.
- Bytes 0xA1,0xA2 then flush -> out0=A1, out1=A2, out2=out3=PAD_BYTE, lane_mask=4'b0011; flush with idx=0 -> no valid_out.
- Assert reset mid-group (2 bytes in) and in HOLD -> all outputs return to reset values immediately, next 4 bytes form a clean group from lane0.
- FLUSH_TIMEOUT_EN, TIMEOUT=4: one byte 0x5A then idle -> valid_out rises after 4th idle edge, lane_mask=4'b0001; without macro -> no valid_out after 20 idle cycles.
